pixel_array_ctrl: RTL and testbench

- Parametrised frame sequencer for an array of PIXEL_SENSOR instances.
- Drives the shared erase/expose/convert phases and generates the digital ramp code during conversion.
- Reads the array out row by row through a valid/ready stream; supports single-shot and continuous frame modes with a runtime exposure length.
- Sits between the pixel array and downstream frame buffering/serialisation; replaces the fixed-duration single-pixel sequencer.

---
 rtl/pixel_array_pkg.sv | 25 ++
 rtl/pixel_array_ramp_gen.sv | 21 ++
 rtl/pixel_array_ctrl.sv | 146 ++++++++++++++
 tb/tb_pixel_array_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_array_pkg.sv
// Shared types and sizing helpers for the pixel array frame sequencer.
package pixel_array_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_EXPOSE,
        S_CONVERT,
        S_RD_SETTLE,
        S_RD_WAIT
    } state_t;

    localparam int DEF_PIXEL_BITS = 8;
    localparam int DEF_RAMP_LEN   = 1 << DEF_PIXEL_BITS;

    function automatic int ramp_len(input int bits);
        return 1 << bits;
    endfunction

    // Never returns zero so single-row arrays still get a legal index port.
    function automatic int row_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_array_ramp_gen.sv
// Conversion ramp counter: counts up while enabled, clears on request.
module ramp_gen #(
    parameter int BITS = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            clr,
    output logic [BITS-1:0] code,
    output logic            last
);

    assign last = &code;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     code <= '0;
        else if (clr)  code <= '0;
        else if (en)   code <= code + BITS'(1);
    end

endmodule

// File: rtl/pixel_array_ctrl.sv
// Frame sequencer for a pixel sensor array: erase/expose/convert phases,
// then row-by-row readout through a valid/ready output register.
module pixel_array_ctrl
    import pixel_array_pkg::*;
#(
    parameter int PIXEL_BITS   = 8,
    parameter int NUM_ROWS     = 2,
    parameter int NUM_COLS     = 2,
    parameter int ERASE_CYCLES = 5,
    parameter int READ_SETTLE  = 2,
    parameter int EXP_W        = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           continuous,
    input  logic [EXP_W-1:0]               cfg_expose,
    output logic                           erase,
    output logic                           expose,
    output logic                           convert,
    output logic [PIXEL_BITS-1:0]          ramp_code,
    output logic [NUM_ROWS-1:0]            row_read,
    input  logic [NUM_COLS*PIXEL_BITS-1:0] pix_bus,
    output logic [NUM_COLS*PIXEL_BITS-1:0] out_data,
    output logic [row_w(NUM_ROWS)-1:0]     out_row,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           frame_done,
    output logic                           busy
);

    localparam int ROW_W = row_w(NUM_ROWS);
    localparam int DW    = NUM_COLS * PIXEL_BITS;
    localparam int CW0   = (EXP_W > $clog2(ERASE_CYCLES + 1)) ? EXP_W : $clog2(ERASE_CYCLES + 1);
    localparam int CNT_W = (CW0 > $clog2(READ_SETTLE + 1)) ? CW0 : $clog2(READ_SETTLE + 1);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [ROW_W-1:0]   row, row_n;
    logic [EXP_W-1:0]   exp_len, exp_len_n;
    logic [DW-1:0]      out_data_n;
    logic [ROW_W-1:0]   out_row_n;
    logic               out_valid_n, frame_done_n;
    logic [NUM_ROWS-1:0] row_read_n;
    logic               ramp_en, ramp_clr, ramp_last;

    ramp_gen #(.BITS(PIXEL_BITS)) u_ramp (
        .clk   (clk),
        .reset (reset),
        .en    (ramp_en),
        .clr   (ramp_clr),
        .code  (ramp_code),
        .last  (ramp_last)
    );

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        row_n        = row;
        exp_len_n    = exp_len;
        out_data_n   = out_data;
        out_row_n    = out_row;
        out_valid_n  = out_valid;
        frame_done_n = 1'b0;
        ramp_en      = 1'b0;
        ramp_clr     = 1'b0;
        unique case (state)
            S_IDLE: if (start) begin
                // A zero exposure would skip the phase entirely; clamp to one cycle.
                exp_len_n = (cfg_expose == '0) ? EXP_W'(1) : cfg_expose;
                cnt_n     = '0;
                state_n   = S_ERASE;
            end
            S_ERASE: if (cnt == CNT_W'(ERASE_CYCLES - 1)) begin
                cnt_n   = '0;
                state_n = S_EXPOSE;
            end else cnt_n = cnt + CNT_W'(1);
            S_EXPOSE: if (cnt == CNT_W'(exp_len) - CNT_W'(1)) begin
                cnt_n   = '0;
                state_n = S_CONVERT;
            end else cnt_n = cnt + CNT_W'(1);
            S_CONVERT: if (ramp_last) begin
                ramp_clr = 1'b1;
                row_n    = '0;
                cnt_n    = '0;
                state_n  = S_RD_SETTLE;
            end else ramp_en = 1'b1;
            S_RD_SETTLE: if (cnt == CNT_W'(READ_SETTLE - 1)) begin
                out_data_n  = pix_bus;
                out_row_n   = row;
                out_valid_n = 1'b1;
                cnt_n       = '0;
                state_n     = S_RD_WAIT;
            end else cnt_n = cnt + CNT_W'(1);
            S_RD_WAIT: if (out_ready) begin
                out_valid_n = 1'b0;
                cnt_n       = '0;
                if (row == ROW_W'(NUM_ROWS - 1)) begin
                    frame_done_n = 1'b1;
                    state_n      = continuous ? S_ERASE : S_IDLE;
                end else begin
                    row_n   = row + ROW_W'(1);
                    state_n = S_RD_SETTLE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Phase outputs are decoded from the next state so they line up with state entry.
        row_read_n = '0;
        if (state_n == S_RD_SETTLE) row_read_n[row_n] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            row        <= '0;
            exp_len    <= '0;
            erase      <= 1'b0;
            expose     <= 1'b0;
            convert    <= 1'b0;
            row_read   <= '0;
            out_data   <= '0;
            out_row    <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            row        <= row_n;
            exp_len    <= exp_len_n;
            erase      <= (state_n == S_ERASE);
            expose     <= (state_n == S_EXPOSE);
            convert    <= (state_n == S_CONVERT);
            row_read   <= row_read_n;
            out_data   <= out_data_n;
            out_row    <= out_row_n;
            out_valid  <= out_valid_n;
            frame_done <= frame_done_n;
            busy       <= (state_n != S_IDLE);
        end
    end

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// Randomised bench for pixel_array_ctrl against a frame-timeline reference model.
module tb_pixel_array_ctrl;

    localparam int PB   = 8;
    localparam int NR   = 2;
    localparam int NC   = 2;
    localparam int E    = 5;
    localparam int RS   = 2;
    localparam int EW   = 16;
    localparam int RAMP = 1 << PB;
    localparam int DW   = NC * PB;

    logic          clk = 1'b0;
    logic          reset, start, continuous, out_ready;
    logic [EW-1:0] cfg_expose;
    logic          erase, expose, convert;
    logic [PB-1:0] ramp_code;
    logic [NR-1:0] row_read;
    logic [DW-1:0] pix_bus, out_data;
    logic [0:0]    out_row;
    logic          out_valid, frame_done, busy;

    pixel_array_ctrl #(
        .PIXEL_BITS(PB), .NUM_ROWS(NR), .NUM_COLS(NC),
        .ERASE_CYCLES(E), .READ_SETTLE(RS), .EXP_W(EW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .continuous(continuous),
        .cfg_expose(cfg_expose), .erase(erase), .expose(expose), .convert(convert),
        .ramp_code(ramp_code), .row_read(row_read), .pix_bus(pix_bus),
        .out_data(out_data), .out_row(out_row), .out_valid(out_valid),
        .out_ready(out_ready), .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: frame timeline anchored at the cycle ERASE is entered,
    // plus readout events driven by the handshake.
    int            cyc = 0;
    bit            act = 1'b0;
    int            f0 = 0, xl = 1, m_row = 0, settle_at = 0, done_at = -1;
    bit            mv = 1'b0;
    logic [DW-1:0] md = '0;
    int            mr = 0;
    int            fd_cnt = 0, exp_cnt = 0, cnv_cnt = 0, last_fd = -1;
    int            n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            if (n_err <= 30)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_all();
        int          k;
        bit          conv_e;
        logic [31:0] rr;
        k      = cyc - f0;
        conv_e = act && k >= E + xl && k < E + xl + RAMP;
        rr     = (act && cyc >= settle_at && cyc < settle_at + RS) ? (32'd1 << m_row) : 32'd0;
        chk("erase",      erase,      act && k < E);
        chk("expose",     expose,     act && k >= E && k < E + xl);
        chk("convert",    convert,    conv_e);
        chk("ramp_code",  ramp_code,  conv_e ? k - E - xl : 0);
        chk("row_read",   row_read,   rr);
        chk("out_valid",  out_valid,  mv);
        chk("out_data",   out_data,   md);
        chk("out_row",    out_row,    mr);
        chk("frame_done", frame_done, cyc == done_at);
        chk("busy",       busy,       act);
        chk("phase_excl", $countones({erase, expose, convert, row_read}) <= 1, 1);
        if (expose)  exp_cnt++;
        if (convert) cnv_cnt++;
        if (frame_done) begin
            fd_cnt++;
            last_fd = cyc;
            chk("expose_len",  exp_cnt, xl);
            chk("convert_len", cnv_cnt, RAMP);
            exp_cnt = 0;
            cnv_cnt = 0;
        end
    endtask

    task automatic new_frame(input int t);
        f0        = t;
        m_row     = 0;
        settle_at = t + E + xl + RAMP;
    endtask

    // Apply the inputs currently driven to the model, clock once, then compare.
    task automatic step();
        pix_bus = DW'($urandom);
        if (!act) begin
            if (start) begin
                act = 1'b1;
                xl  = (cfg_expose == 0) ? 1 : int'(cfg_expose);
                new_frame(cyc + 1);
            end
        end else if (cyc == settle_at + RS - 1) begin
            mv = 1'b1;
            md = pix_bus;
            mr = m_row;
        end else if (mv && out_ready) begin
            mv = 1'b0;
            if (m_row < NR - 1) begin
                m_row++;
                settle_at = cyc + 1;
            end else begin
                done_at = cyc + 1;
                if (continuous) new_frame(cyc + 1);
                else act = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        check_all();
    endtask

    task automatic rst_checks();
        chk("rst_erase", erase, 0);       chk("rst_expose", expose, 0);
        chk("rst_convert", convert, 0);   chk("rst_ramp", ramp_code, 0);
        chk("rst_row_read", row_read, 0); chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);     chk("rst_row", out_row, 0);
        chk("rst_done", frame_done, 0);   chk("rst_busy", busy, 0);
    endtask

    task automatic model_reset();
        act = 1'b0; mv = 1'b0; md = '0; mr = 0; done_at = -1;
        exp_cnt = 0; cnv_cnt = 0;
    endtask

    // Asynchronous reset asserted between clock edges.
    task automatic async_reset();
        reset = 1'b1;
        #1;
        rst_checks();
        model_reset();
        @(posedge clk);
        #1;
        cyc++;
        reset = 1'b0;
        check_all();
    endtask

    task automatic start_frame(input int cfg);
        cfg_expose = EW'(cfg);
        start      = 1'b1;
        step();
        start      = 1'b0;
    endtask

    task automatic run_until_idle(input int bound, input bit noise, input bit rnd);
        int n = 0;
        while (act && n < bound) begin
            start = noise ? ($urandom_range(0, 5) == 0) : 1'b0;
            if (rnd) begin
                out_ready  = ($urandom_range(0, 3) != 0);
                continuous = continuous && ($urandom_range(0, 199) != 0);
            end
            step();
            n++;
        end
        start = 1'b0;
        chk("idle_timeout", act, 0);
    endtask

    initial begin
        int t_erase, fd0, n;
        reset = 1'b1; start = 1'b0; continuous = 1'b0; out_ready = 1'b1;
        cfg_expose = '0; pix_bus = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_checks();
        reset = 1'b0;
        check_all();

        // Single shot, exposure 10, ready held high.
        start_frame(10);
        t_erase = cyc;
        run_until_idle(2000, 1'b1, 1'b0);
        chk("frame_len", last_fd - t_erase, E + 10 + RAMP + NR * (RS + 1));
        repeat (3) step();

        // Zero exposure clamps to one cycle; mid-exposure config change ignored.
        start_frame(0);
        cfg_expose = 16'd50;
        run_until_idle(2000, 1'b1, 1'b0);
        start_frame(8);
        n = 0;
        while (act && cyc - f0 < E + 2 && n < 100) begin step(); n++; end
        cfg_expose = 16'd50;
        run_until_idle(2000, 1'b1, 1'b0);

        // Backpressure on row 0 for 20 cycles.
        out_ready = 1'b0;
        start_frame(3);
        n = 0;
        while (!mv && n < 2000) begin step(); n++; end
        chk("bp_reached_valid", mv, 1);
        repeat (20) step();
        out_ready = 1'b1;
        run_until_idle(2000, 1'b0, 1'b0);

        // Continuous mode: drop the flag partway through the third frame.
        continuous = 1'b1;
        fd0 = fd_cnt;
        start_frame(4);
        n = 0;
        while (fd_cnt - fd0 < 2 && n < 2000) begin step(); n++; end
        repeat (100) step();
        continuous = 1'b0;
        run_until_idle(2000, 1'b1, 1'b0);
        chk("cont_frames", fd_cnt - fd0, 3);

        // Reset mid-conversion, then a clean frame.
        start_frame(6);
        n = 0;
        while (act && cyc - f0 < E + xl + 100 && n < 2000) begin step(); n++; end
        chk("ramp_before_reset", ramp_code, 100);
        async_reset();
        fd0 = fd_cnt;
        repeat (5) step();
        start_frame(7);
        run_until_idle(2000, 1'b1, 1'b0);
        chk("post_reset_frames", fd_cnt - fd0, 1);

        // Random frames: exposure, backpressure, stray starts, continuous toggling.
        repeat (8) begin
            repeat ($urandom_range(0, 4)) step();
            continuous = ($urandom_range(0, 3) == 0);
            start_frame($urandom_range(0, 30));
            run_until_idle(6000, 1'b1, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
